maxnet_relu_update: RTL and testbench

//   Downstream stage of the 4-input PLU array in the Maxnet datapath. Captures the four
//   PLU net sums (IEEE-754 single), applies ReLU, and holds the results as the

---
 rtl/maxnet_relu_update_if.sv | 27 ++
 rtl/maxnet_relu_update.sv | 137 +++++++++++++
 tb/tb_maxnet_relu_update.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxnet_relu_update_if.sv
// Bundle of the Maxnet ReLU/update stage signals: run control, initial activations,
// PLU array handshake, activation feedback and run results.
interface maxnet_relu_update_if #(
    parameter int IW = 5
);
    logic          start;
    logic [31:0]   x1, x2, x3, x4;
    logic [31:0]   net1, net2, net3, net4;
    logic          net_done;
    logic          plu_start;
    logic [31:0]   a1, a2, a3, a4;
    logic          done;
    logic [1:0]    winner;
    logic          no_winner;
    logic          timeout;
    logic [IW-1:0] iter_cnt;

    modport master (
        output start, x1, x2, x3, x4, net1, net2, net3, net4, net_done,
        input  plu_start, a1, a2, a3, a4, done, winner, no_winner, timeout, iter_cnt
    );

    modport slave (
        input  start, x1, x2, x3, x4, net1, net2, net3, net4, net_done,
        output plu_start, a1, a2, a3, a4, done, winner, no_winner, timeout, iter_cnt
    );
endinterface

// File: rtl/maxnet_relu_update.sv
// Maxnet iteration sequencer: captures PLU net sums through ReLU into the activation
// registers, re-launches the PLU array until one activation survives or MAX_ITER runs.
module maxnet_relu_update #(
    parameter int MAX_ITER = 16,
    parameter int IW       = 5
) (
    input logic                clk,
    input logic                rst,
    maxnet_relu_update_if.slave bus
);
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_KICK,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] a_q [4];
    logic [IW-1:0]     iter_cnt_q;
    logic [1:0]        winner_q;
    logic              no_winner_q;
    logic              timeout_q;

    logic [3:0]        nz;
    logic [2:0]        nz_cnt;
    logic [1:0]        win_idx;
    logic              at_max;

    // Sign bit set clears the word, so -0 and negative NaNs also map to +0.
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? '0 : v;
    endfunction

    always_comb begin
        nz      = '0;
        nz_cnt  = '0;
        win_idx = '0;
        for (int i = 0; i < 4; i++) begin
            nz[i]  = |a_q[i][DATA_W-2:0];
            nz_cnt = nz_cnt + {2'b00, nz[i]};
        end
        for (int i = 3; i >= 0; i--) begin
            if (nz[i]) win_idx = 2'(i);
        end
    end

    assign at_max = (iter_cnt_q == IW'(MAX_ITER));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_nxt = S_CHECK;
            S_CHECK: begin
                if (nz_cnt <= 3'd1) state_nxt = S_DONE;
                else if (at_max)    state_nxt = S_DONE;
                else                state_nxt = S_KICK;
            end
            S_KICK:  state_nxt = S_WAIT;
            S_WAIT:  if (bus.net_done) state_nxt = S_CHECK;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.plu_start = (state == S_KICK);
        bus.done      = (state == S_DONE);
    end

    // Activations move only on start capture or net capture, so the PLU inputs are
    // frozen for the whole of WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) a_q[i] <= '0;
            iter_cnt_q  <= '0;
            winner_q    <= '0;
            no_winner_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q[0]      <= relu(bus.x1);
                        a_q[1]      <= relu(bus.x2);
                        a_q[2]      <= relu(bus.x3);
                        a_q[3]      <= relu(bus.x4);
                        iter_cnt_q  <= '0;
                        winner_q    <= '0;
                        no_winner_q <= 1'b0;
                        timeout_q   <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (nz_cnt > 3'd1 && at_max) timeout_q <= 1'b1;
                end
                S_WAIT: begin
                    if (bus.net_done) begin
                        a_q[0] <= relu(bus.net1);
                        a_q[1] <= relu(bus.net2);
                        a_q[2] <= relu(bus.net3);
                        a_q[3] <= relu(bus.net4);
                        if (!at_max) iter_cnt_q <= iter_cnt_q + IW'(1);
                    end
                end
                S_DONE: begin
                    if (nz_cnt == 3'd1) begin
                        winner_q <= win_idx;
                    end else if (nz_cnt == 3'd0) begin
                        no_winner_q <= 1'b1;
                        winner_q    <= '0;
                    end else begin
                        winner_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.a1        = a_q[0];
    assign bus.a2        = a_q[1];
    assign bus.a3        = a_q[2];
    assign bus.a4        = a_q[3];
    assign bus.iter_cnt  = iter_cnt_q;
    assign bus.winner    = winner_q;
    assign bus.no_winner = no_winner_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_maxnet_relu_update.sv
// Bench for maxnet_relu_update: a reference Maxnet model fills a scoreboard at each start,
// a PLU responder answers plu_start, and each run's results are popped at done.
module tb_maxnet_relu_update;
    localparam int MAX_ITER = 2;
    localparam int IW       = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maxnet_relu_update_if #(.IW(IW)) ifc ();

    maxnet_relu_update #(.MAX_ITER(MAX_ITER), .IW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef logic [3:0][31:0] vec_t;
    typedef struct {
        vec_t       a;
        logic [1:0] winner;
        logic       no_winner;
        logic       timeout;
        int         iters;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   plu_cnt = 0;
    int   done_cnt = 0;
    int   req_n = 0;
    int   served_n = 0;
    int   resp_cnt = -1;
    int   resp_delay = 3;
    bit   resp_en = 1'b0;
    vec_t a_obs;

    assign a_obs = {ifc.a4, ifc.a3, ifc.a2, ifc.a1};

    function automatic vec_t mk(input logic [31:0] v1, v2, v3, v4);
        return {v4, v3, v2, v1};
    endfunction

    function automatic vec_t relu_v(input vec_t v);
        vec_t r;
        for (int i = 0; i < 4; i++) r[i] = v[i][31] ? 32'h0 : v[i];
        return r;
    endfunction

    function automatic int count_nz(input vec_t v);
        int n = 0;
        for (int i = 0; i < 4; i++) if (v[i][30:0] != 31'h0) n++;
        return n;
    endfunction

    // Reference run where the PLU array returns the same net vector every iteration.
    function automatic exp_t model(input vec_t x, input vec_t net);
        exp_t e;
        int   nz;
        e.a = relu_v(x);
        e.iters = 0;
        e.winner = 2'd0;
        e.no_winner = 1'b0;
        e.timeout = 1'b0;
        for (int k = 0; k <= MAX_ITER; k++) begin
            nz = count_nz(e.a);
            if (nz <= 1) break;
            if (e.iters == MAX_ITER) begin
                e.timeout = 1'b1;
                break;
            end
            e.a = relu_v(net);
            e.iters++;
        end
        nz = count_nz(e.a);
        if (nz == 0) e.no_winner = 1'b1;
        else if (nz == 1)
            for (int i = 0; i < 4; i++) if (e.a[i][30:0] != 31'h0) e.winner = 2'(i);
        return e;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (ifc.plu_start === 1'b1) plu_cnt++;
            if (ifc.done === 1'b1) done_cnt++;
        end
    end

    // PLU stand-in: net_done resp_delay cycles after plu_start, or on explicit request.
    initial begin
        ifc.net_done = 1'b0;
        forever begin
            @(negedge clk);
            ifc.net_done = 1'b0;
            if (served_n != req_n) begin
                served_n++;
                ifc.net_done = 1'b1;
            end else if (resp_cnt == 0) begin
                ifc.net_done = 1'b1;
                resp_cnt = -1;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
            end
            if (resp_en && ifc.plu_start === 1'b1) resp_cnt = resp_delay - 1;
            if (rst !== 1'b1) resp_cnt = -1;
        end
    end

    task automatic drive_start(input vec_t x);
        @(negedge clk);
        {ifc.x4, ifc.x3, ifc.x2, ifc.x1} = x;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic set_net(input vec_t n);
        {ifc.net4, ifc.net3, ifc.net2, ifc.net1} = n;
    endtask

    task automatic wait_done(output bit seen, output int cyc);
        seen = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) begin
                seen = 1'b1;
                cyc = i;
            end
        end
    endtask

    task automatic wait_plu(input int target, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (plu_cnt >= target) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit   seen;
        int   p0, d0;
        vec_t x = mk(32'h3F800000, 32'h40000000, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (a_obs !== '0) begin errors++; $display("FAIL reset_a: got %h want 0", a_obs); end
        checks++;
        if ({ifc.winner, ifc.no_winner, ifc.timeout, ifc.iter_cnt, ifc.plu_start, ifc.done} !== '0) begin
            errors++;
            $display("FAIL reset_flags: got w=%0d nw=%b to=%b it=%0d ps=%b dn=%b want all 0",
                     ifc.winner, ifc.no_winner, ifc.timeout, ifc.iter_cnt, ifc.plu_start, ifc.done);
        end
        rst = 1'b1;
        resp_en = 1'b0;
        p0 = plu_cnt;
        drive_start(x);
        wait_plu(p0 + 1, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL reset_kick: got no plu_start want one"); end
        repeat (2) @(negedge clk);
        checks++;
        if (a_obs !== x) begin errors++; $display("FAIL reset_capture: got %h want %h", a_obs, x); end
        d0 = done_cnt;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (a_obs !== '0 || ifc.iter_cnt !== '0) begin
            errors++;
            $display("FAIL reset_midrun: got a=%h it=%0d want 0", a_obs, ifc.iter_cnt);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != d0 || plu_cnt != p0 + 1) begin
            errors++;
            $display("FAIL reset_quiet: got done+%0d plu+%0d want done+0 plu+1", done_cnt - d0, plu_cnt - p0);
        end
    endtask

    task automatic test_converge();
        bit   seen;
        int   cyc, p0;
        exp_t e;
        vec_t x = mk(32'h3F800000, 32'hBE800000, 32'h00000000, 32'h80000000);
        sb.push_back(model(x, '0));
        p0 = plu_cnt;
        drive_start(x);
        wait_done(seen, cyc);
        checks++;
        if (!seen || cyc != 1) begin errors++; $display("FAIL conv_latency: got seen=%b cyc=%0d want 1", seen, cyc); end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (a_obs !== e.a) begin errors++; $display("FAIL conv_a: got %h want %h", a_obs, e.a); end
        checks++;
        if ({ifc.winner, ifc.no_winner, ifc.timeout} !== {e.winner, e.no_winner, e.timeout} || ifc.iter_cnt !== IW'(e.iters)) begin
            errors++;
            $display("FAIL conv_result: got w=%0d nw=%b to=%b it=%0d want w=%0d nw=%b to=%b it=%0d",
                     ifc.winner, ifc.no_winner, ifc.timeout, ifc.iter_cnt, e.winner, e.no_winner, e.timeout, e.iters);
        end
        checks++;
        if (plu_cnt != p0) begin errors++; $display("FAIL conv_no_kick: got %0d pulses want 0", plu_cnt - p0); end
    endtask

    task automatic test_iterate(input string name, input vec_t x, input vec_t net, input int delay);
        bit   seen;
        int   cyc, p0, d0;
        exp_t e;
        set_net(net);
        resp_delay = delay;
        resp_en = 1'b1;
        sb.push_back(model(x, net));
        p0 = plu_cnt;
        d0 = done_cnt;
        drive_start(x);
        wait_done(seen, cyc);
        checks++;
        if (!seen) begin errors++; $display("FAIL %s_done: got no done want done", name); end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (a_obs !== e.a) begin errors++; $display("FAIL %s_a: got %h want %h", name, a_obs, e.a); end
        checks++;
        if ({ifc.winner, ifc.no_winner, ifc.timeout} !== {e.winner, e.no_winner, e.timeout}) begin
            errors++;
            $display("FAIL %s_flags: got w=%0d nw=%b to=%b want w=%0d nw=%b to=%b",
                     name, ifc.winner, ifc.no_winner, ifc.timeout, e.winner, e.no_winner, e.timeout);
        end
        checks++;
        if (ifc.iter_cnt !== IW'(e.iters) || plu_cnt - p0 != e.iters) begin
            errors++;
            $display("FAIL %s_iters: got it=%0d plu=%0d want %0d", name, ifc.iter_cnt, plu_cnt - p0, e.iters);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s_done_once: got %0d want 1", name, done_cnt - d0); end
        resp_en = 1'b0;
    endtask

    task automatic test_ignored();
        bit   seen;
        int   cyc, p0, d0;
        exp_t e;
        vec_t saved;
        vec_t x = mk(32'h3F800000, 32'h40000000, 32'h0, 32'h0);
        resp_en = 1'b0;
        set_net(mk(32'h0, 32'h3F800000, 32'h0, 32'h0));
        sb.push_back(model(x, mk(32'h0, 32'h3F800000, 32'h0, 32'h0)));
        p0 = plu_cnt;
        d0 = done_cnt;
        drive_start(x);
        wait_plu(p0 + 1, seen);
        repeat (2) @(negedge clk);
        saved = a_obs;
        {ifc.x4, ifc.x3, ifc.x2, ifc.x1} = mk(32'h0, 32'h0, 32'h0, 32'h3F800000);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (!seen || saved !== x || a_obs !== x || plu_cnt != p0 + 1 || done_cnt != d0) begin
            errors++;
            $display("FAIL ign_start_wait: got a=%h plu+%0d done+%0d want a=%h plu+1 done+0",
                     a_obs, plu_cnt - p0, done_cnt - d0, x);
        end
        req_n++;
        wait_done(seen, cyc);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (!seen || a_obs !== e.a || ifc.winner !== e.winner || ifc.iter_cnt !== IW'(e.iters)) begin
            errors++;
            $display("FAIL ign_finish: got seen=%b a=%h w=%0d it=%0d want a=%h w=%0d it=%0d",
                     seen, a_obs, ifc.winner, ifc.iter_cnt, e.a, e.winner, e.iters);
        end
        p0 = plu_cnt;
        d0 = done_cnt;
        set_net(mk(32'h40000000, 32'h40000000, 32'h0, 32'h0));
        req_n++;
        repeat (4) @(negedge clk);
        checks++;
        if (a_obs !== e.a || ifc.iter_cnt !== IW'(e.iters) || plu_cnt != p0 || done_cnt != d0) begin
            errors++;
            $display("FAIL ign_net_idle: got a=%h it=%0d plu+%0d done+%0d want a=%h it=%0d no pulses",
                     a_obs, ifc.iter_cnt, plu_cnt - p0, done_cnt - d0, e.a, e.iters);
        end
    endtask

    task automatic test_back_to_back();
        bit   seen;
        int   cyc, d1;
        exp_t e;
        vec_t x  = mk(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h0);
        vec_t x2 = mk(32'h0, 32'h0, 32'h3F800000, 32'h0);
        vec_t n  = mk(32'hBE800000, 32'h3F800000, 32'hBF000000, 32'h0);
        set_net(n);
        resp_delay = 1;
        resp_en = 1'b1;
        sb.push_back(model(x, n));
        drive_start(x);
        wait_done(seen, cyc);
        {ifc.x4, ifc.x3, ifc.x2, ifc.x1} = x2;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || a_obs !== e.a || ifc.winner !== e.winner || ifc.iter_cnt !== IW'(e.iters)) begin
            errors++;
            $display("FAIL b2b_first: got seen=%b a=%h w=%0d it=%0d want a=%h w=%0d it=%0d",
                     seen, a_obs, ifc.winner, ifc.iter_cnt, e.a, e.winner, e.iters);
        end
        d1 = done_cnt;
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt != d1 || a_obs !== e.a) begin
            errors++;
            $display("FAIL b2b_start_in_done: got done+%0d a=%h want done+0 a=%h", done_cnt - d1, a_obs, e.a);
        end
        sb.push_back(model(x2, n));
        drive_start(x2);
        wait_done(seen, cyc);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (!seen || cyc != 1 || a_obs !== e.a || ifc.winner !== e.winner || ifc.iter_cnt !== IW'(e.iters)) begin
            errors++;
            $display("FAIL b2b_second: got seen=%b cyc=%0d a=%h w=%0d it=%0d want cyc=1 a=%h w=%0d it=%0d",
                     seen, cyc, a_obs, ifc.winner, ifc.iter_cnt, e.a, e.winner, e.iters);
        end
        resp_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ifc.start = 1'b0;
        {ifc.x4, ifc.x3, ifc.x2, ifc.x1} = '0;
        set_net('0);
        repeat (3) @(negedge clk);
        test_reset();
        test_converge();
        test_iterate("single", mk(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h0),
                     mk(32'hBE800000, 32'h3F800000, 32'hBF000000, 32'h0), 3);
        test_iterate("allneg", mk(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h0),
                     mk(32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000), 3);
        test_iterate("timeout", mk(32'h3F800000, 32'h40000000, 32'h0, 32'h0),
                     mk(32'h3F800000, 32'h40000000, 32'h0, 32'h0), 2);
        test_ignored();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
